ir_tx: RTL

IR_TX -- requirements
Module: ir_tx

---
 rtl/ir_tx_if.sv | 20 ++
 rtl/ir_tx.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/ir_tx_if.sv
// ir_tx_if -- frame request / status bundle for the NEC-style IR transmitter.
//   START    : frame request (master -> slave)
//   REPEAT   : 1 = repeat frame, 0 = data frame (master -> slave)
//   DATA     : 32-bit payload, bit 0 sent first (master -> slave)
//   BUSY     : frame (including trailing gap) in progress (slave -> master)
//   DONE     : one-cycle completion pulse (slave -> master)
//   IR_ENV   : burst envelope (slave -> master)
//   IRDA_TXD : envelope AND carrier (slave -> master)
interface ir_tx_if;
  logic        START;
  logic        REPEAT;
  logic [31:0] DATA;
  logic        BUSY;
  logic        DONE;
  logic        IR_ENV;
  logic        IRDA_TXD;

  modport master (output START, REPEAT, DATA, input BUSY, DONE, IR_ENV, IRDA_TXD);
  modport slave  (input START, REPEAT, DATA, output BUSY, DONE, IR_ENV, IRDA_TXD);
endinterface

// File: rtl/ir_tx.sv
// ir_tx -- NEC-style IR frame transmitter.
// Sends leader burst, leader space, 32 pulse-distance bits (LSB first) and a
// stop burst, then holds an idle gap. Repeat frames use the short leader space
// and skip the data bits. The burst envelope is gated with a ~38 kHz carrier.
//   CLOCK_50 : system clock, rising edge
//   RSTN     : asynchronous active-low reset
//   irb      : ir_tx_if.slave (START/REPEAT/DATA in; BUSY/DONE/IR_ENV/IRDA_TXD out)
module ir_tx #(
  parameter int LEAD_MARK   = 450000,
  parameter int LEAD_SPACE  = 225000,
  parameter int REP_SPACE   = 112500,
  parameter int BIT_MARK    = 28125,
  parameter int ONE_SPACE   = 84375,
  parameter int CARRIER_DIV = 1316,
  parameter int GAP_TIME    = 2000000
) (
  input  logic    CLOCK_50,
  input  logic    RSTN,
  ir_tx_if.slave  irb
);

  localparam int CW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;

  localparam logic [21:0] LM_M1 = 22'(LEAD_MARK - 1);
  localparam logic [21:0] LS_M1 = 22'(LEAD_SPACE - 1);
  localparam logic [21:0] RS_M1 = 22'(REP_SPACE - 1);
  localparam logic [21:0] BM_M1 = 22'(BIT_MARK - 1);
  localparam logic [21:0] OS_M1 = 22'(ONE_SPACE - 1);
  localparam logic [21:0] GP_M1 = 22'(GAP_TIME - 1);
  localparam logic [CW-1:0] CAR_TOP  = CW'(CARRIER_DIV - 1);
  localparam logic [CW-1:0] CAR_HALF = CW'(CARRIER_DIV / 2);

  typedef enum logic [2:0] {IDLE, LMARK, LSPACE, BMARK, BSPACE, SMARK, GAP} state_t;

  state_t        state_q, state_d;
  logic [21:0]   cnt_q, cnt_d;
  logic [31:0]   shift_q, shift_d;
  logic [4:0]    idx_q, idx_d;
  logic          rep_q, rep_d;
  logic [CW-1:0] car_q, car_d;
  logic          env_q, env_d;
  logic          txd_q, txd_d;
  logic          done_q, done_d;
  logic [21:0]   len_m1;
  logic          last;

  always_ff @(posedge CLOCK_50 or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      rep_q   <= 1'b0;
      car_q   <= '0;
      env_q   <= 1'b0;
      txd_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      car_q   <= car_d;
      env_q   <= env_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    done_d  = 1'b0;

    // Terminal count of the shared phase counter for the current state.
    case (state_q)
      LMARK:        len_m1 = LM_M1;
      LSPACE:       len_m1 = rep_q ? RS_M1 : LS_M1;
      BMARK, SMARK: len_m1 = BM_M1;
      BSPACE:       len_m1 = shift_q[0] ? OS_M1 : BM_M1;
      GAP:          len_m1 = GP_M1;
      default:      len_m1 = '0;
    endcase
    last  = (cnt_q == len_m1);
    cnt_d = last ? '0 : cnt_q + 22'd1;

    case (state_q)
      IDLE: begin
        if (irb.START) begin
          state_d = LMARK;
          shift_d = irb.DATA;
          rep_d   = irb.REPEAT;
          idx_d   = '0;
        end
      end
      LMARK:  if (last) state_d = LSPACE;
      LSPACE: if (last) state_d = rep_q ? SMARK : BMARK;
      BMARK:  if (last) state_d = BSPACE;
      BSPACE: begin
        if (last) begin
          if (idx_q == 5'd31) begin
            state_d = SMARK;
          end else begin
            state_d = BMARK;
            idx_d   = idx_q + 5'd1;
            shift_d = {1'b0, shift_q[31:1]};
          end
        end
      end
      SMARK:  if (last) state_d = GAP;
      GAP: begin
        if (last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from next-state values so envelope and
    // modulated output change on the same edge as the state itself.
    env_d = (state_d == LMARK) || (state_d == BMARK) || (state_d == SMARK);
    if (env_d && (state_d != state_q))
      car_d = '0;
    else if (car_q == CAR_TOP)
      car_d = '0;
    else
      car_d = car_q + CW'(1);
    txd_d = env_d && (car_d < CAR_HALF);
  end

  assign irb.BUSY     = (state_q != IDLE);
  assign irb.DONE     = done_q;
  assign irb.IR_ENV   = env_q;
  assign irb.IRDA_TXD = txd_q;

endmodule
